// File: rtl/counter_pkg.sv
// Shared definitions for the universal counter and its command sequencer:
// counter mode encodings, sequencer state type and small decode helpers.
package counter_pkg;

  localparam logic [1:0] MODO_ARRIBA = 2'b00;
  localparam logic [1:0] MODO_ABAJO  = 2'b01;
  localparam logic [1:0] MODO_ABAJO3 = 2'b10;
  localparam logic [1:0] MODO_CARGA  = 2'b11;

  localparam int RCO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    FIN  = 2'b11
  } seq_state_t;

  // A command skips the counting phase when it only loads or asks for zero cycles.
  function automatic logic skips_run(input logic [1:0] modo, input logic ciclos_zero);
    return (modo == MODO_CARGA) || ciclos_zero;
  endfunction

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Command channel of the counter sequencer: valid/ready handshake carrying
// mode, parallel-load value and cycle count.
interface counter_cmd_sequencer_if #(
  parameter int W  = 16,
  parameter int CW = 8
);
  logic          valid;
  logic          ready;
  logic [1:0]    modo;
  logic [W-1:0]  dato;
  logic [CW-1:0] ciclos;

  modport master (output valid, modo, dato, ciclos, input ready);
  modport slave  (input valid, modo, dato, ciclos, output ready);
endinterface

// File: rtl/counter_cmd_sequencer_sat_event_counter.sv
// Saturating event counter: clear wins over increment, holds at all-ones.
// Exposes the next value so a caller can capture the count including this edge's event.
module sat_event_counter
  import counter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [RCO_CNT_W-1:0] count,
  output logic [RCO_CNT_W-1:0] count_next
);

  localparam logic [RCO_CNT_W-1:0] CNT_MAX = '1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count != CNT_MAX)) begin
      count_next = count + RCO_CNT_W'(1);
    end
  end

  // NOTE: reset is synchronous and active-high: it only acts at a rising clock edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so all flops update together at the edge.
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for the universal counter: one parallel-load cycle, N count
// cycles in the requested mode, then reports the final Q and the RCO events seen.
module counter_cmd_sequencer
  import counter_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  counter_cmd_sequencer_if.slave   cmd,
  output logic                     enb,
  output logic [1:0]               modo,
  output logic [W-1:0]             d,
  input  logic [W-1:0]             q,
  input  logic                     rco,
  output logic                     done,
  output logic [W-1:0]             q_final,
  output logic [RCO_CNT_W-1:0]     rco_total
);

  seq_state_t          state;
  seq_state_t          state_next;
  logic [1:0]          modo_q;
  logic [W-1:0]        dato_q;
  logic [CW-1:0]       ciclos_q;
  logic [CW-1:0]       rem;
  logic                accept;
  logic                rco_inc;
  logic [RCO_CNT_W-1:0] rco_cnt;
  logic [RCO_CNT_W-1:0] rco_cnt_next;

  assign cmd.ready = (state == IDLE) && !reset;
  assign accept    = cmd.valid && cmd.ready;
  // RCO only matters once the load is done and the counter is actually stepping.
  assign rco_inc   = rco && ((state == RUN) || (state == FIN));

  sat_event_counter u_rco_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .inc        (rco_inc),
    .count      (rco_cnt),
    .count_next (rco_cnt_next)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = skips_run(modo_q, ciclos_q == '0) ? FIN : RUN;
      RUN:  if (rem == CW'(1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command fields are captured only on accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      modo_q   <= MODO_ARRIBA;
      dato_q   <= '0;
      ciclos_q <= '0;
    end else if (accept) begin
      modo_q   <= cmd.modo;
      dato_q   <= cmd.dato;
      ciclos_q <= cmd.ciclos;
    end
  end

  // rem starts at CICLOS on leaving LOAD; zero-cycle commands never enter RUN, so no underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
    end else if (state == LOAD) begin
      rem <= ciclos_q;
    end else if (state == RUN) begin
      rem <= rem - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      q_final   <= '0;
      rco_total <= '0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        q_final   <= q;
        rco_total <= rco_cnt_next;
      end
    end
  end

  // Moore decode of the counter controls from state and the latched command.
  always_comb begin
    enb  = 1'b0;
    modo = MODO_ARRIBA;
    d    = '0;
    unique case (state)
      LOAD: begin
        enb  = 1'b1;
        modo = MODO_CARGA;
        d    = dato_q;
      end
      RUN: begin
        enb  = 1'b1;
        modo = modo_q;
        d    = dato_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Self-checking bench: sequencer driving a behavioural W=16 universal counter,
// directed vector table, hand-written corner sequences and randomized commands.
module tb_counter_cmd_sequencer;

  localparam int W  = 16;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enb;
  logic [1:0]   modo;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         rco;
  logic         done;
  logic [W-1:0] q_final;
  logic [7:0]   rco_total;
  logic         rco_force;
  logic [W-1:0] cnt_q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_cmd_sequencer_if #(.W(W), .CW(CW)) cmd_bus ();

  counter_cmd_sequencer #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd_bus),
    .enb       (enb),
    .modo      (modo),
    .d         (d),
    .q         (q),
    .rco       (rco),
    .done      (done),
    .q_final   (q_final),
    .rco_total (rco_total)
  );

  // Behavioural universal counter (00 up, 01 down, 10 down-by-3, 11 load).
  always @(posedge clk) begin
    if (enb) begin
      case (modo)
        2'b00:   cnt_q <= cnt_q + 16'd1;
        2'b01:   cnt_q <= cnt_q - 16'd1;
        2'b10:   cnt_q <= cnt_q - 16'd3;
        default: cnt_q <= d;
      endcase
    end
  end
  assign q   = cnt_q;
  assign rco = rco_force | (enb && ((modo == 2'b00 && cnt_q == 16'hFFFF) ||
                                    (modo == 2'b01 && cnt_q == 16'h0000) ||
                                    (modo == 2'b10 && cnt_q <  16'd3)));

  typedef struct {
    logic [15:0] q;
    logic [7:0]  rco;
    int          lat;
    int          enb_cyc;
  } result_t;

  typedef struct {
    string       name;
    logic [1:0]  m;
    logic [15:0] dato;
    logic [7:0]  n;
    logic [15:0] exp_q;
    logic [7:0]  exp_rco;
    int          exp_lat;
    int          exp_enb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: final value is dato + step*N in plain integers; RCO events are the
  // number of 2^16 boundaries crossed; a forced RCO counts every RUN/FIN edge.
  function automatic result_t ref_model(input logic [1:0] m, input logic [15:0] dato,
                                        input int n, input bit forced);
    result_t r;
    int      steps;
    longint  step;
    longint  tot;
    longint  wraps;
    steps     = (m == 2'b11 || n == 0) ? 0 : n;
    r.lat     = 3 + steps;
    r.enb_cyc = 1 + steps;
    step      = (m == 2'b00) ? 1 : (m == 2'b01) ? -1 : (m == 2'b10) ? -3 : 0;
    tot       = longint'(dato) + step * longint'(steps);
    r.q       = tot[15:0];
    if (step > 0)      wraps = tot / 65536;
    else if (tot < 0)  wraps = (-tot - 1) / 65536 + 1;
    else               wraps = 0;
    if (forced) wraps = longint'(steps) + 1;
    r.rco = (wraps > 255) ? 8'hFF : wraps[7:0];
    return r;
  endfunction

  // Issues one command, keeps VALID high with scrambled fields while busy,
  // and returns in the DONE cycle (sampled 1 time unit after the edge).
  task automatic run_cmd(input string name, input logic [1:0] m, input logic [15:0] dato,
                         input logic [7:0] n, input result_t e);
    int waited, lat, enb_cyc, load_cyc, run_bad;
    cmd_bus.valid  = 1'b1;
    cmd_bus.modo   = m;
    cmd_bus.dato   = dato;
    cmd_bus.ciclos = n;
    waited = 0;
    while (!cmd_bus.ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, " ready"}, 32'(cmd_bus.ready), 32'(1));
    if (!cmd_bus.ready) begin
      cmd_bus.valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_bus.modo   = 2'($urandom);
    cmd_bus.dato   = 16'($urandom);
    cmd_bus.ciclos = 8'($urandom);
    lat = 0; enb_cyc = 0; load_cyc = 0; run_bad = 0;
    for (int j = 1; j <= 400; j++) begin
      if (j == 1) check({name, " done pulse"}, 32'(done), 32'(0));
      if (enb) begin
        enb_cyc++;
        if (modo == 2'b11) begin
          load_cyc++;
          check({name, " load d"}, 32'(d), 32'(dato));
        end else if (modo != m) begin
          run_bad++;
        end
      end
      @(posedge clk); #1;
      if (done) begin
        lat = j + 1;
        break;
      end
    end
    check({name, " latency"},  32'(lat),      32'(e.lat));
    check({name, " enb cyc"},  32'(enb_cyc),  32'(e.enb_cyc));
    check({name, " load cyc"}, 32'(load_cyc), 32'(1));
    check({name, " run modo"}, 32'(run_bad),  32'(0));
    check({name, " q_final"},  32'(q_final),  32'(e.q));
    check({name, " rco_tot"},  32'(rco_total), 32'(e.rco));
    check({name, " ready@done"}, 32'(cmd_bus.ready), 32'(1));
    cmd_bus.valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " enb"},       32'(enb),       32'(0));
    check({name, " modo"},      32'(modo),      32'(0));
    check({name, " d"},         32'(d),         32'(0));
    check({name, " done"},      32'(done),      32'(0));
    check({name, " q_final"},   32'(q_final),   32'(0));
    check({name, " rco_total"}, 32'(rco_total), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    vecs[6];
    result_t e;

    vecs[0] = '{"up",      2'b00, 16'hFFF0, 8'd16, 16'h0000, 8'd1, 19, 17};
    vecs[1] = '{"down",    2'b01, 16'hFFFF, 8'd16, 16'hFFEF, 8'd0, 19, 17};
    vecs[2] = '{"down3",   2'b10, 16'hFFFF, 8'd11, 16'hFFDE, 8'd0, 14, 12};
    vecs[3] = '{"load",    2'b11, 16'h1234, 8'd9,  16'h1234, 8'd0, 3,  1};
    vecs[4] = '{"zero",    2'b00, 16'h00A5, 8'd0,  16'h00A5, 8'd0, 3,  1};
    vecs[5] = '{"b2b",     2'b01, 16'h0003, 8'd4,  16'hFFFF, 8'd1, 7,  5};

    reset          = 1'b1;
    rco_force      = 1'b0;
    cmd_bus.valid  = 1'b0;
    cmd_bus.modo   = 2'b00;
    cmd_bus.dato   = '0;
    cmd_bus.ciclos = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 32'(cmd_bus.ready), 32'(0));
    check_reset_outputs("rst");
    reset = 1'b0;
    #1;
    check("post-rst ready", 32'(cmd_bus.ready), 32'(1));

    // Directed table, issued back to back on each DONE cycle.
    for (int i = 0; i < 6; i++) begin
      e.q       = vecs[i].exp_q;
      e.rco     = vecs[i].exp_rco;
      e.lat     = vecs[i].exp_lat;
      e.enb_cyc = vecs[i].exp_enb;
      run_cmd(vecs[i].name, vecs[i].m, vecs[i].dato, vecs[i].n, e);
    end

    // Randomized commands, biased toward the wrap boundaries.
    for (int i = 0; i < 20; i++) begin
      logic [1:0]  m;
      logic [15:0] dv;
      logic [7:0]  nv;
      m  = 2'($urandom_range(0, 3));
      nv = 8'($urandom_range(0, 40));
      case ($urandom_range(0, 2))
        0:       dv = 16'($urandom);
        1:       dv = 16'hFFE0 + 16'($urandom_range(0, 31));
        default: dv = 16'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      run_cmd($sformatf("rand%0d", i), m, dv, nv, ref_model(m, dv, int'(nv), 1'b0));
    end

    // RCO stuck high: IDLE/LOAD edges ignored, count saturates at FF.
    rco_force = 1'b1;
    run_cmd("sat3",   2'b01, 16'd100, 8'd3,   ref_model(2'b01, 16'd100, 3, 1'b1));
    run_cmd("sat255", 2'b00, 16'd0,   8'd255, ref_model(2'b00, 16'd0, 255, 1'b1));
    run_cmd("sat_ld", 2'b11, 16'd7,   8'd0,   ref_model(2'b11, 16'd7, 0, 1'b1));
    rco_force = 1'b0;
    run_cmd("pre-abort", 2'b01, 16'd100, 8'd3, ref_model(2'b01, 16'd100, 3, 1'b0));

    // Abort in RUN cycle 5 of the "up" command.
    cmd_bus.valid  = 1'b1;
    cmd_bus.modo   = 2'b00;
    cmd_bus.dato   = 16'hFFF0;
    cmd_bus.ciclos = 8'd16;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    check("abort enb in run", 32'(enb), 32'(1));
    reset = 1'b1;
    #1;
    check("abort ready in rst", 32'(cmd_bus.ready), 32'(0));
    @(posedge clk); #1;
    check("abort ready", 32'(cmd_bus.ready), 32'(0));
    check_reset_outputs("abort");
    @(posedge clk); #1;
    check("abort done2", 32'(done), 32'(0));
    reset = 1'b0;
    #1;
    check("abort rel ready", 32'(cmd_bus.ready), 32'(1));
    check_reset_outputs("abort rel");
    e.q = 16'h0000; e.rco = 8'd1; e.lat = 19; e.enb_cyc = 17;
    run_cmd("post-abort", 2'b00, 16'hFFF0, 8'd16, e);

    @(posedge clk); #1;
    check("final done low", 32'(done), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
